// File: rtl/caf_slice_core.sv
// One frequency-offset slice of the cross-ambiguity engine: captures `length` x/y samples,
// rotates y by the slice's NCO, and reports the peak |C[k]|^2 over all circular lags.
module caf_slice_core #(
  parameter int phase_bits          = 10,
  parameter int xi_bits             = 12,
  parameter int xq_bits             = 12,
  parameter int yi_bits             = 12,
  parameter int yq_bits             = 12,
  parameter int i_bits              = 24,
  parameter int q_bits              = 24,
  parameter int length              = 5,
  parameter int length_counter_bits = 3,
  parameter int out_max_bits        = 64
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [phase_bits-1:0]          freq_step,
  input  logic                           freq_step_valid,
  input  logic                           neg_shift,
  input  logic                           m_axis_tvalid,
  input  logic signed [xi_bits-1:0]      xi,
  input  logic signed [xq_bits-1:0]      xq,
  input  logic signed [yi_bits-1:0]      yi,
  input  logic signed [yq_bits-1:0]      yq,
  output logic                           s_axis_tready,
  input  logic                           m_axis_tready,
  output logic [out_max_bits-1:0]        out_max,
  output logic [length_counter_bits-1:0] index,
  output logic                           s_axis_tvalid
);

  localparam int cw        = length_counter_bits;
  localparam int ys_bits   = yi_bits + 1;
  localparam int ymax_bits = (yi_bits > yq_bits) ? yi_bits : yq_bits;
  localparam int pw        = yi_bits + ymax_bits + 2;
  localparam int aw_max    = (i_bits > q_bits) ? i_bits : q_bits;
  localparam int fw        = 2 * aw_max + 1;
  localparam int rom_depth = 2 ** phase_bits;
  localparam real amp      = real'((1 << (yi_bits - 1)) - 1);
  localparam real two_pi   = 6.283185307179586;
  localparam logic [cw-1:0] last_idx = cw'(length - 1);

  typedef enum logic [1:0] {IDLE, CAPTURE, CORRELATE, DONE} state_t;

  state_t state, next_state;

  logic [phase_bits-1:0] step_reg, phase;
  logic                  neg_reg;
  logic [cw-1:0]         n_cnt, k_cnt, m_cnt;
  logic                  accept;

  logic signed [xi_bits-1:0] x_i_mem  [length];
  logic signed [xq_bits-1:0] x_q_mem  [length];
  logic signed [ys_bits-1:0] ys_i_mem [length];
  logic signed [ys_bits-1:0] ys_q_mem [length];

  logic signed [yi_bits-1:0] cos_rom [rom_depth];
  logic signed [yi_bits-1:0] sin_rom [rom_depth];

  // Quarter-wave symmetry is not exploited: a full table keeps the lookup a single index.
  for (genvar g = 0; g < rom_depth; g++) begin : g_rom
    localparam real ang = two_pi * real'(g) / real'(rom_depth);
    localparam real cr  = amp * $cos(ang);
    localparam real sr  = amp * $sin(ang);
    localparam int  ci  = (cr >= 0.0) ? $rtoi(cr + 0.5) : $rtoi(cr - 0.5);
    localparam int  si  = (sr >= 0.0) ? $rtoi(sr + 0.5) : $rtoi(sr - 0.5);
    assign cos_rom[g] = yi_bits'(ci);
    assign sin_rom[g] = yi_bits'(si);
  end

  assign accept = s_axis_tready & m_axis_tvalid;

  logic signed [pw-1:0]      yi_e, yq_e, c_e, s_e, rot_i, rot_q;
  logic signed [ys_bits-1:0] ys_i_new, ys_q_new;

  always_comb begin
    yi_e = pw'(yi);
    yq_e = pw'(yq);
    c_e  = pw'(cos_rom[phase]);
    s_e  = pw'(sin_rom[phase]);
    if (neg_reg) begin
      rot_i = yi_e * c_e + yq_e * s_e;
      rot_q = yq_e * c_e - yi_e * s_e;
    end else begin
      rot_i = yi_e * c_e - yq_e * s_e;
      rot_q = yq_e * c_e + yi_e * s_e;
    end
    ys_i_new = ys_bits'(rot_i >>> (yi_bits - 1));
    ys_q_new = ys_bits'(rot_q >>> (yi_bits - 1));
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      x_i_mem[n_cnt]  <= xi;
      x_q_mem[n_cnt]  <= xq;
      ys_i_mem[n_cnt] <= ys_i_new;
      ys_q_mem[n_cnt] <= ys_q_new;
    end
  end

  logic signed [i_bits-1:0]  acc_i, acc_i_next, xa_i, xa_q, ya_i, ya_q;
  logic signed [q_bits-1:0]  acc_q, acc_q_next, xb_i, xb_q, yb_i, yb_q;
  logic signed [fw-1:0]      re_e, im_e;
  logic [fw-1:0]             mag_u;
  logic [out_max_bits-1:0]   mag_t, best_max, new_best;
  logic [cw-1:0]             best_idx, new_idx;
  logic                      take;

  // m_cnt tracks (n_cnt + k_cnt) mod length so no modulo is needed in the datapath.
  always_comb begin
    xa_i       = i_bits'(x_i_mem[n_cnt]);
    xa_q       = i_bits'(x_q_mem[n_cnt]);
    ya_i       = i_bits'(ys_i_mem[m_cnt]);
    ya_q       = i_bits'(ys_q_mem[m_cnt]);
    xb_i       = q_bits'(x_i_mem[n_cnt]);
    xb_q       = q_bits'(x_q_mem[n_cnt]);
    yb_i       = q_bits'(ys_i_mem[m_cnt]);
    yb_q       = q_bits'(ys_q_mem[m_cnt]);
    acc_i_next = acc_i + xa_i * ya_i + xa_q * ya_q;
    acc_q_next = acc_q + xb_q * yb_i - xb_i * yb_q;
    re_e       = fw'(acc_i_next);
    im_e       = fw'(acc_q_next);
    mag_u      = $unsigned(re_e * re_e + im_e * im_e);
    mag_t      = out_max_bits'(mag_u);
    take       = (k_cnt == '0) || (mag_t > best_max);
    new_best   = take ? mag_t : best_max;
    new_idx    = take ? k_cnt : best_idx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    if (freq_step_valid) begin
      next_state = CAPTURE;
    end else begin
      case (state)
        CAPTURE:   if (accept && n_cnt == last_idx) next_state = CORRELATE;
        CORRELATE: if (n_cnt == last_idx && k_cnt == last_idx) next_state = DONE;
        DONE:      if (s_axis_tvalid && m_axis_tready) next_state = IDLE;
        default:   next_state = state;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_axis_tready <= 1'b0;
      s_axis_tvalid <= 1'b0;
      out_max       <= '0;
      index         <= '0;
      step_reg      <= '0;
      neg_reg       <= 1'b0;
      phase         <= '0;
      n_cnt         <= '0;
      k_cnt         <= '0;
      m_cnt         <= '0;
      acc_i         <= '0;
      acc_q         <= '0;
      best_max      <= '0;
      best_idx      <= '0;
    end else begin
      s_axis_tready <= (next_state == CAPTURE);
      s_axis_tvalid <= (next_state == DONE);
      if (freq_step_valid) begin
        step_reg <= freq_step;
        neg_reg  <= neg_shift;
        phase    <= '0;
        n_cnt    <= '0;
        k_cnt    <= '0;
        m_cnt    <= '0;
        acc_i    <= '0;
        acc_q    <= '0;
      end else begin
        case (state)
          CAPTURE: begin
            if (accept) begin
              phase <= phase + step_reg;
              n_cnt <= (n_cnt == last_idx) ? '0 : n_cnt + cw'(1);
            end
          end
          CORRELATE: begin
            if (n_cnt == last_idx) begin
              acc_i    <= '0;
              acc_q    <= '0;
              n_cnt    <= '0;
              k_cnt    <= k_cnt + cw'(1);
              m_cnt    <= k_cnt + cw'(1);
              best_max <= new_best;
              best_idx <= new_idx;
              if (k_cnt == last_idx) begin
                out_max <= new_best;
                index   <= new_idx;
              end
            end else begin
              acc_i <= acc_i_next;
              acc_q <= acc_q_next;
              n_cnt <= n_cnt + cw'(1);
              m_cnt <= (m_cnt == last_idx) ? '0 : m_cnt + cw'(1);
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_caf_slice_core.sv
// Randomised self-checking bench for caf_slice_core against a direct arithmetic model of the
// NCO rotation, circular cross-correlation and peak search.
module tb_caf_slice_core;

  localparam int L = 5;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic [9:0]         freq_step = '0;
  logic               freq_step_valid = 1'b0;
  logic               neg_shift = 1'b0;
  logic               m_axis_tvalid = 1'b0;
  logic signed [11:0] xi = '0, xq = '0, yi = '0, yq = '0;
  logic               s_axis_tready;
  logic               m_axis_tready = 1'b0;
  logic [63:0]        out_max;
  logic [2:0]         index;
  logic               s_axis_tvalid;

  caf_slice_core dut (
    .clk(clk), .rst_n(rst_n),
    .freq_step(freq_step), .freq_step_valid(freq_step_valid), .neg_shift(neg_shift),
    .m_axis_tvalid(m_axis_tvalid), .xi(xi), .xq(xq), .yi(yi), .yq(yq),
    .s_axis_tready(s_axis_tready), .m_axis_tready(m_axis_tready),
    .out_max(out_max), .index(index), .s_axis_tvalid(s_axis_tvalid)
  );

  always #5 clk = ~clk;

  int     vectors = 0, miscompares = 0;
  int     x_i[L], x_q[L], y_i[L], y_q[L];
  longint exp_max = 0;
  int     exp_idx = 0;
  int     accepted = 0;

  task automatic checkOutput(input string name, input longint actual, input longint expected);
    vectors++;
    if (actual != expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  function automatic longint roundAway(input real v);
    return (v >= 0.0) ? longint'($rtoi(v + 0.5)) : longint'($rtoi(v - 0.5));
  endfunction

  function automatic longint wrapBits(input longint v, input int bits);
    longint one = 1;
    longint span = one << bits;
    longint r = v % span;
    if (r < 0) r += span;
    if (r >= span / 2) r -= span;
    return r;
  endfunction

  task automatic runModel(input int step, input bit neg, output longint mx, output int mi);
    longint ysi[L], ysq[L];
    longint c, s, sg, ti, tq, re, im, mag;
    int theta, m;
    mx = 0;
    mi = 0;
    sg = neg ? -1 : 1;
    for (int n = 0; n < L; n++) begin
      theta = (n * step) % 1024;
      c = roundAway(2047.0 * $cos(6.283185307179586 * theta / 1024.0));
      s = roundAway(2047.0 * $sin(6.283185307179586 * theta / 1024.0));
      ti = y_i[n] * c - sg * y_q[n] * s;
      tq = y_q[n] * c + sg * y_i[n] * s;
      ysi[n] = wrapBits(ti >>> 11, 13);
      ysq[n] = wrapBits(tq >>> 11, 13);
    end
    for (int k = 0; k < L; k++) begin
      re = 0;
      im = 0;
      for (int n = 0; n < L; n++) begin
        m = (n + k) % L;
        re += x_i[n] * ysi[m] + x_q[n] * ysq[m];
        im += x_q[n] * ysi[m] - x_i[n] * ysq[m];
      end
      re = wrapBits(re, 24);
      im = wrapBits(im, 24);
      mag = re * re + im * im;
      if (k == 0 || mag > mx) begin
        mx = mag;
        mi = k;
      end
    end
  endtask

  // Every cycle a result is presented it must equal the model, which also covers stall stability.
  always @(negedge clk) begin
    if (rst_n && s_axis_tvalid) begin
      checkOutput("out_max", out_max, exp_max);
      checkOutput("index", longint'(index), longint'(exp_idx));
    end
  end

  always @(posedge clk) begin
    if (rst_n && s_axis_tready && m_axis_tvalid) accepted++;
  end

  function automatic int rnd12();
    return int'($urandom_range(0, 4095)) - 2048;
  endfunction

  task automatic fillRandom();
    for (int n = 0; n < L; n++) begin
      x_i[n] = rnd12(); x_q[n] = rnd12(); y_i[n] = rnd12(); y_q[n] = rnd12();
    end
  endtask

  task automatic fillConst(input int xv, input int yv);
    for (int n = 0; n < L; n++) begin
      x_i[n] = xv; x_q[n] = 0; y_i[n] = yv; y_q[n] = 0;
    end
  endtask

  task automatic fillImpulse(input int yv);
    fillConst(0, 0);
    x_i[0] = 100;
    y_i[2] = yv;
  endtask

  task automatic startStep(input int step, input bit neg);
    @(negedge clk);
    freq_step = 10'(step);
    neg_shift = neg;
    freq_step_valid = 1'b1;
    @(negedge clk);
    freq_step_valid = 1'b0;
  endtask

  // gap_mode: 0 continuous, 1 valid on alternate cycles, 2 random gaps.
  task automatic applyStimulus(input int step, input bit neg, input int gap_mode, input int stall);
    int idx, cyc, lat;
    bit send, acc;
    runModel(step, neg, exp_max, exp_idx);
    startStep(step, neg);
    checkOutput("tready_rise", longint'(s_axis_tready), 1);
    accepted = 0;
    idx = 0;
    cyc = 0;
    while (idx < L && cyc < 200) begin
      send = (gap_mode == 0) ? 1'b1 : (gap_mode == 1) ? (cyc % 2 == 0) : 1'($urandom_range(0, 1));
      m_axis_tvalid = send;
      xi = 12'(x_i[idx]); xq = 12'(x_q[idx]); yi = 12'(y_i[idx]); yq = 12'(y_q[idx]);
      acc = send && s_axis_tready;
      @(negedge clk);
      if (acc) idx++;
      cyc++;
    end
    checkOutput("capture_done", longint'(idx), L);
    checkOutput("tready_fall", longint'(s_axis_tready), 0);
    m_axis_tvalid = 1'b1;
    xi = 12'(rnd12()); yi = 12'(rnd12());
    repeat (3) @(negedge clk);
    m_axis_tvalid = 1'b0;
    checkOutput("accepted", longint'(accepted), L);
    lat = 3;
    while (!s_axis_tvalid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    checkOutput("tvalid_rise", longint'(s_axis_tvalid), 1);
    checkOutput("latency_ok", longint'(lat <= L * L + 4), 1);
    repeat (stall) @(negedge clk);
    checkOutput("tvalid_held", longint'(s_axis_tvalid), 1);
    m_axis_tready = 1'b1;
    @(negedge clk);
    m_axis_tready = 1'b0;
    checkOutput("tvalid_drop", longint'(s_axis_tvalid), 0);
    checkOutput("tready_idle", longint'(s_axis_tready), 0);
    checkOutput("hold_max", out_max, exp_max);
    checkOutput("hold_index", longint'(index), longint'(exp_idx));
  endtask

  task automatic feedPartial(input int nsamp);
    startStep(int'($urandom_range(0, 1023)), 1'($urandom_range(0, 1)));
    m_axis_tvalid = 1'b1;
    for (int n = 0; n < nsamp; n++) begin
      xi = 12'(rnd12()); xq = 12'(rnd12()); yi = 12'(rnd12()); yq = 12'(rnd12());
      @(negedge clk);
    end
    m_axis_tvalid = 1'b0;
  endtask

  initial begin
    longint ma;
    int ia, s_rot;
    repeat (3) @(negedge clk);
    checkOutput("rst_tready", longint'(s_axis_tready), 0);
    checkOutput("rst_tvalid", longint'(s_axis_tvalid), 0);
    checkOutput("rst_out_max", out_max, 0);
    checkOutput("rst_index", longint'(index), 0);
    rst_n = 1'b1;
    m_axis_tvalid = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("idle_tready", longint'(s_axis_tready), 0);
    m_axis_tvalid = 1'b0;

    // With A = 2047 the unit-gain rotation loses an LSB: y = 1 becomes 0 and y = 10 becomes 9.
    fillConst(1, 1);
    applyStimulus(0, 1'b0, 0, 2);
    checkOutput("tie1_model_max", exp_max, 0);
    checkOutput("tie1_index", longint'(index), 0);
    fillConst(1, 2);
    applyStimulus(0, 1'b0, 0, 2);
    checkOutput("tie2_model_max", exp_max, 25);
    checkOutput("tie2_out_max", out_max, 25);
    checkOutput("tie2_index", longint'(index), 0);
    fillImpulse(10);
    applyStimulus(0, 1'b0, 0, 10);
    checkOutput("imp10_out_max", out_max, 810000);
    checkOutput("imp10_index", longint'(index), 2);
    fillImpulse(11);
    applyStimulus(0, 1'b0, 1, 10);
    checkOutput("imp11_model_max", exp_max, 1000000);
    checkOutput("imp11_out_max", out_max, 1000000);
    checkOutput("imp11_index", longint'(index), 2);

    feedPartial(2);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("midrst_tready", longint'(s_axis_tready), 0);
    checkOutput("midrst_tvalid", longint'(s_axis_tvalid), 0);
    checkOutput("midrst_out_max", out_max, 0);
    checkOutput("midrst_index", longint'(index), 0);
    @(negedge clk);
    rst_n = 1'b1;
    m_axis_tvalid = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("midrst_no_capture", longint'(s_axis_tready), 0);
    m_axis_tvalid = 1'b0;
    fillImpulse(11);
    applyStimulus(0, 1'b0, 0, 0);

    for (int r = 0; r < 3; r++) begin
      fillRandom();
      s_rot = int'($urandom_range(1, 1023));
      applyStimulus(s_rot, 1'b1, 2, int'($urandom_range(0, 4)));
      ma = exp_max;
      ia = exp_idx;
      applyStimulus(1024 - s_rot, 1'b0, 0, 1);
      checkOutput("rot_sym_max", exp_max, ma);
      checkOutput("rot_sym_index", longint'(exp_idx), longint'(ia));
    end

    feedPartial(3);
    fillRandom();
    applyStimulus(int'($urandom_range(0, 1023)), 1'b0, 0, 0);

    for (int r = 0; r < 8; r++) begin
      fillRandom();
      applyStimulus(int'($urandom_range(0, 1023)), 1'($urandom_range(0, 1)),
                    int'($urandom_range(0, 2)), int'($urandom_range(0, 5)));
    end

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, vectors %0d", vectors);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
